pmips_fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register for PMIPS (16-bit instr, 3-bit opcode).

---
 rtl/pmips_fetch_stage.sv | 103 ++++++++++
 tb/tb_pmips_fetch_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pmips_fetch_stage.sv
// PMIPS instruction-fetch stage: req/ack instruction-memory front end with a one-entry
// prefetch buffer, branch redirect/squash, and the IF/ID pipeline register.
module pmips_fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'hE000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        PCStall,
   input  logic        PCSrc,
   input  logic [15:0] BranchTarget,
   output logic        IMemReq,
   output logic [15:0] IMemAddr,
   input  logic [15:0] IMemRdata,
   input  logic        IMemAck,
   output logic [15:0] Instruction,
   output logic [2:0]  OpCode,
   output logic [15:0] PCPlus2,
   output logic        IFIDValid
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL, S_SQUASH} state_t;

   state_t      state, state_nxt;
   logic [15:0] fetch_pc, fetch_pc_nxt, fetch_pc_inc, target;
   logic [15:0] buf_word, buf_pc2;
   logic        fetch_ack, req_open;
   logic        target_lsb_unused;

   assign target            = {BranchTarget[15:1], 1'b0};
   assign target_lsb_unused = BranchTarget[0];
   assign fetch_pc_inc      = fetch_pc + 16'd2;
   assign fetch_ack         = (state == S_FETCH) && IMemAck;
   // A request still open after this edge must be drained before a new address goes out.
   assign req_open          = ((state == S_FETCH) || (state == S_SQUASH)) && !IMemAck;
   assign fetch_pc_nxt      = PCSrc ? target : (fetch_ack ? fetch_pc_inc : fetch_pc);
   assign OpCode            = Instruction[15:13];

   always_ff @(posedge clock) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: assign a default before any branch so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      if (PCSrc) begin
         state_nxt = req_open ? S_SQUASH : S_FETCH;
      end else begin
         case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (IMemAck && PCStall) state_nxt = S_FULL;
            S_FULL:   if (!PCStall) state_nxt = S_FETCH;
            S_SQUASH: if (IMemAck) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      IMemReq = (state == S_FETCH) || (state == S_SQUASH);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         IMemAddr    <= RESET_PC;
         Instruction <= NOP_INSTR;
         PCPlus2     <= 16'h0000;
         IFIDValid   <= 1'b0;
      end else begin
         fetch_pc <= fetch_pc_nxt;
         if (state_nxt != S_SQUASH) IMemAddr <= fetch_pc_nxt;
         if (PCSrc) begin
            Instruction <= NOP_INSTR;
            IFIDValid   <= 1'b0;
         end else if (!PCStall) begin
            if (fetch_ack) begin
               Instruction <= IMemRdata;
               PCPlus2     <= fetch_pc_inc;
               IFIDValid   <= 1'b1;
            end else if (state == S_FULL) begin
               Instruction <= buf_word;
               PCPlus2     <= buf_pc2;
               IFIDValid   <= 1'b1;
            end else begin
               Instruction <= NOP_INSTR;
               IFIDValid   <= 1'b0;
            end
         end
      end
   end

   // NOTE: the buffer has no reset; it is read only in S_FULL, which is entered only by writing it.
   always_ff @(posedge clock) begin
      if (fetch_ack && PCStall && !PCSrc) begin
         buf_word <= IMemRdata;
         buf_pc2  <= fetch_pc_inc;
      end
   end

endmodule

// File: tb/tb_pmips_fetch_stage.sv
// Randomized scoreboard bench for pmips_fetch_stage: a stream model predicts the ordered valid
// instruction words, a ROM responder adds random latency, and a monitor checks every IF/ID update.
module tb_pmips_fetch_stage;

   localparam logic [15:0] RESET_PC  = 16'h0000;
   localparam logic [15:0] NOP_INSTR = 16'hE000;

   logic        clock = 1'b0;
   logic        reset, PCStall, PCSrc, IMemAck;
   logic [15:0] BranchTarget, IMemRdata;
   logic        IMemReq, IFIDValid;
   logic [15:0] IMemAddr, Instruction, PCPlus2;
   logic [2:0]  OpCode;

   always #5 clock = ~clock;

   pmips_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clock(clock), .reset(reset), .PCStall(PCStall), .PCSrc(PCSrc),
      .BranchTarget(BranchTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
      .IMemRdata(IMemRdata), .IMemAck(IMemAck), .Instruction(Instruction),
      .OpCode(OpCode), .PCPlus2(PCPlus2), .IFIDValid(IFIDValid)
   );

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc2;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          valid_count = 0;
   int          idle_cycles = 0;
   int          lat_min = 0;
   int          lat_max = 0;
   logic [15:0] model_pc = RESET_PC;
   logic        applied_reset = 1'b0;
   logic        applied_stall = 1'b0;
   logic        applied_src = 1'b0;

   function automatic logic [15:0] rom_word(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: after reset or a taken branch the valid stream restarts at the new address and
   // proceeds in +2 steps; each stream entry is pushed as soon as that stimulus is consumed.
   task automatic step(input logic rst, input logic stall, input logic src, input logic [15:0] tgt);
      @(posedge clock);
      applied_reset = reset;
      applied_stall = PCStall;
      applied_src   = PCSrc;
      if (!applied_reset) begin
         exp_q.delete();
         model_pc = RESET_PC;
      end else if (applied_src) begin
         exp_q.delete();
         model_pc = BranchTarget & 16'hFFFE;
      end
      while (exp_q.size() < 4) begin
         exp_q.push_back('{instr: rom_word(model_pc), pc2: model_pc + 16'd2});
         model_pc = model_pc + 16'd2;
      end
      #1;
      reset        = rst;
      PCStall      = stall;
      PCSrc        = src;
      BranchTarget = tgt;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
   endtask

   // ROM responder with a random per-request latency; also checks the request stays put until acked.
   logic        rom_pending = 1'b0;
   int          rom_wait = 0;
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [15:0] prev_addr = 16'h0000;

   always @(negedge clock) begin
      if (applied_reset && prev_req && !prev_ack) begin
         check("req_held", 64'(IMemReq), 64'(1'b1));
         check("addr_stable", 64'(IMemAddr), 64'(prev_addr));
      end
      if (IMemReq) begin
         if (!rom_pending) begin
            rom_pending = 1'b1;
            rom_wait    = $urandom_range(lat_max, lat_min);
         end
         if (rom_wait == 0) begin
            IMemAck     = 1'b1;
            IMemRdata   = rom_word(IMemAddr);
            rom_pending = 1'b0;
         end else begin
            IMemAck   = 1'b0;
            IMemRdata = 16'($urandom);
            rom_wait--;
         end
      end else begin
         IMemAck     = 1'b0;
         IMemRdata   = 16'($urandom);
         rom_pending = 1'b0;
      end
      prev_req  = IMemReq;
      prev_ack  = IMemAck;
      prev_addr = IMemAddr;
   end

   // Monitor: pops one expected word for every fresh valid IF/ID load.
   logic [32:0] prev_ifid = '0;

   always @(negedge clock) begin
      exp_t e;
      logic popped;
      popped = 1'b0;
      if (!applied_reset) begin
         check("rst_instr", 64'(Instruction), 64'(NOP_INSTR));
         check("rst_pcplus2", 64'(PCPlus2), 64'(16'h0000));
         check("rst_valid", 64'(IFIDValid), 64'(1'b0));
         check("rst_req", 64'(IMemReq), 64'(1'b0));
         check("rst_addr", 64'(IMemAddr), 64'(RESET_PC));
         idle_cycles = 0;
      end else begin
         check("opcode", 64'(OpCode), 64'(Instruction[15:13]));
         if (applied_src) begin
            check("branch_bubble", 64'({IFIDValid, Instruction}), 64'({1'b0, NOP_INSTR}));
         end else if (applied_stall) begin
            check("stall_hold", 64'({IFIDValid, Instruction, PCPlus2}), 64'(prev_ifid));
         end else if (IFIDValid) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 64'(exp_q.size()), 64'(1));
            end else begin
               e = exp_q.pop_front();
               check("instr", 64'(Instruction), 64'(e.instr));
               check("pcplus2", 64'(PCPlus2), 64'(e.pc2));
               valid_count++;
               popped = 1'b1;
            end
         end else begin
            check("bubble_word", 64'(Instruction), 64'(NOP_INSTR));
         end
         if (popped) idle_cycles = 0;
         else idle_cycles++;
         if (idle_cycles > 64) begin
            check("liveness", 64'(idle_cycles), 64'(64));
            idle_cycles = 0;
         end
      end
      prev_ifid = {IFIDValid, Instruction, PCPlus2};
   end

   initial begin
      reset = 1'b0; PCStall = 1'b0; PCSrc = 1'b0; BranchTarget = 16'h0000;
      IMemAck = 1'b0; IMemRdata = 16'h0000;
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      run(12);
      // Stall for three cycles, then release.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
      run(6);
      // Slow ROM, then redirect while a request is pending.
      lat_min = 3; lat_max = 3;
      run(12);
      step(1'b1, 1'b0, 1'b1, 16'h0040);
      run(14);
      // Branch together with stall; odd target has bit 0 dropped.
      lat_min = 0; lat_max = 1;
      step(1'b1, 1'b1, 1'b1, 16'h0081);
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      run(10);
      // Address wrap at the top of the address space.
      lat_min = 0; lat_max = 0;
      step(1'b1, 1'b0, 1'b1, 16'hFFF9);
      run(10);
      // Reset while a squashed request is still waiting for its ack.
      lat_min = 3; lat_max = 3;
      run(2);
      step(1'b1, 1'b0, 1'b1, 16'h0100);
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      run(12);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            lat_min = 0;
            lat_max = $urandom_range(3, 0);
         end
         if ($urandom % 600 == 0) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            step(1'b0, 1'b0, 1'b0, 16'h0000);
         end else begin
            step(1'b1, ($urandom % 4) == 0, ($urandom % 12) == 0, 16'($urandom));
         end
      end
      run(8);
      check("valid_words_min", 64'(valid_count >= 300), 64'(1'b1));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
